// File: rtl/stage0_instruction_fetch_if.sv
// Purpose: handshake and data bundle between the fetch stage, its memory and decode.
// Latency: none; this only groups signals.
// Backpressure: stall_i from decode holds the output; mem_ack_i completes a fetch.
//
// Ports (from the fetch stage's point of view, modport master):
//   mem_req_o/mem_addr_o        : word fetch request, held until mem_ack_i
//   mem_ack_i/mem_data_i        : fetch completion and returned instruction word
//   stall_i                     : decode cannot accept a new instruction this cycle
//   redirect_i/redirect_addr_i  : one-cycle control-flow change and its target
//   valid_o/instruction_o/pc_o  : IF/ID output register
//   exception_o                 : sticky misaligned-fetch-target flag
interface stage0_instruction_fetch_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        valid_o;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        exception_o;

    modport master (
        output mem_req_o, mem_addr_o, valid_o, instruction_o, pc_o, exception_o,
        input  mem_ack_i, mem_data_i, stall_i, redirect_i, redirect_addr_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, valid_o, instruction_o, pc_o, exception_o,
        output mem_ack_i, mem_data_i, stall_i, redirect_i, redirect_addr_i
    );
endinterface

// File: rtl/stage0_instruction_fetch.sv
// Purpose: fetch stage - owns the fetch PC, issues word requests, fills the IF/ID register.
// Latency: instruction appears on valid_o/instruction_o/pc_o one cycle after its mem_ack_i.
// Backpressure: stall_i holds the output; one more word is parked in a skid buffer, then fetch pauses.
//
// Ports: clock_i (rising edge), resetn_i (async, active low), bus (stage0_instruction_fetch_if.master).
module stage0_instruction_fetch #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic                         clock_i,
    input  logic                         resetn_i,
    stage0_instruction_fetch_if.master   bus
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,      // request outstanding at pc_fetch
        S_HOLD,     // skid buffer full, waiting for decode to drain the output
        S_DISCARD,  // wrong-path request still outstanding; its data will be dropped
        S_HALT      // misaligned target; wait for an aligned redirect
    } state_t;

    state_t      state;
    logic [31:0] pc_fetch;
    logic [31:0] discard_addr;  // address of the abandoned request, kept on the bus until acked
    logic [31:0] skid_dat;      // skid occupancy is implied by state == S_HOLD
    logic [31:0] skid_pc;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic        exc_q;         // doubles as the pending-halt flag: both set and clear together

    logic        out_free;
    logic        redir_misaligned;

    assign out_free         = !valid_q || !bus.stall_i;
    assign redir_misaligned = (bus.redirect_addr_i[1:0] != 2'b00);

    // Gated by reset so no request escapes while the memory is itself held in reset.
    assign bus.mem_req_o  = resetn_i && ((state == S_REQ) || (state == S_DISCARD));
    // pc_fetch already moved to the redirect target, but the old request must stay stable.
    assign bus.mem_addr_o = (state == S_DISCARD) ? discard_addr : pc_fetch;

    assign bus.valid_o       = valid_q;
    assign bus.instruction_o = instr_q;
    assign bus.pc_o          = pc_q;
    assign bus.exception_o   = exc_q;

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state        <= S_REQ;
            pc_fetch     <= BOOT_ADDR;
            discard_addr <= BOOT_ADDR;
            skid_dat     <= NOP_INSTR;
            skid_pc      <= 32'h0;
            instr_q      <= NOP_INSTR;
            pc_q         <= 32'h0;
            valid_q      <= 1'b0;
            exc_q        <= 1'b0;
        end else if (bus.redirect_i) begin
            // Redirect beats stall and ack: the output and any parked word are wrong-path.
            valid_q  <= 1'b0;
            pc_fetch <= bus.redirect_addr_i;
            exc_q    <= redir_misaligned;
            case (state)
                S_REQ: begin
                    if (bus.mem_ack_i) begin
                        state <= redir_misaligned ? S_HALT : S_REQ;
                    end else begin
                        state        <= S_DISCARD;
                        discard_addr <= pc_fetch;
                    end
                end
                S_DISCARD: begin
                    if (bus.mem_ack_i) begin
                        state <= redir_misaligned ? S_HALT : S_REQ;
                    end
                end
                default: begin
                    // S_HOLD and S_HALT have nothing outstanding at the memory.
                    state <= redir_misaligned ? S_HALT : S_REQ;
                end
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (bus.mem_ack_i) begin
                        pc_fetch <= pc_fetch + 32'd4;
                        if (out_free) begin
                            instr_q <= bus.mem_data_i;
                            pc_q    <= pc_fetch;
                            valid_q <= 1'b1;
                        end else begin
                            skid_dat <= bus.mem_data_i;
                            skid_pc  <= pc_fetch;
                            state    <= S_HOLD;
                        end
                    end else if (out_free) begin
                        valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    // Output is always valid here, so stall_i alone decides the drain.
                    if (!bus.stall_i) begin
                        instr_q <= skid_dat;
                        pc_q    <= skid_pc;
                        valid_q <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (out_free) begin
                        valid_q <= 1'b0;
                    end
                    if (bus.mem_ack_i) begin
                        state <= exc_q ? S_HALT : S_REQ;
                    end
                end
                S_HALT: begin
                    valid_q <= 1'b0;
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage0_instruction_fetch.sv
module tb_stage0_instruction_fetch;

    localparam logic [31:0] K   = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    always #5 clk = ~clk;

    stage0_instruction_fetch_if ifc();

    stage0_instruction_fetch #(.BOOT_ADDR(32'h0)) dut (
        .clock_i  (clk),
        .resetn_i (rstn),
        .bus      (ifc)
    );

    // Memory model: every word reads back as its address xor K.
    assign ifc.mem_data_i = ifc.mem_addr_o ^ K;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        ack;
        logic        stall;
        logic        redir;
        logic [31:0] raddr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_exc;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic ack, input logic stall, input logic redir,
                                input logic [31:0] raddr, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_pc, input logic e_exc);
        vec_t v;
        v.ack = ack; v.stall = stall; v.redir = redir; v.raddr = raddr;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_exc = e_exc;
        return v;
    endfunction

    task automatic drive(input logic ack, input logic stall, input logic redir, input logic [31:0] raddr);
        ifc.mem_ack_i       = ack;
        ifc.stall_i         = stall;
        ifc.redirect_i      = redir;
        ifc.redirect_addr_i = raddr;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(ifc.mem_req_o),   32'd0);
        chk({tag, "_valid"}, 32'(ifc.valid_o),     32'd0);
        chk({tag, "_instr"}, ifc.instruction_o,    NOP);
        chk({tag, "_pc"},    ifc.pc_o,             32'd0);
        chk({tag, "_exc"},   32'(ifc.exception_o), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          consumed;
        logic [31:0] exp_pc;
        logic        need_bubble;
        logic        addr_hold;
        logic [31:0] held_addr;
        logic        st, rd, ak;
        logic [31:0] ra;

        drive(1'b0, 1'b0, 1'b0, 32'h0);

        // Directed table, run straight out of reset with BOOT_ADDR = 0.
        vt.push_back(mk(1,0,0,32'h0,        1,32'h4,       1,32'h0,       0));
        vt.push_back(mk(1,0,0,32'h0,        1,32'h8,       1,32'h4,       0));
        vt.push_back(mk(1,1,0,32'h0,        0,32'hC,       1,32'h4,       0));
        vt.push_back(mk(0,1,0,32'h0,        0,32'hC,       1,32'h4,       0));
        vt.push_back(mk(0,1,0,32'h0,        0,32'hC,       1,32'h4,       0));
        vt.push_back(mk(0,0,0,32'h0,        1,32'hC,       1,32'h8,       0));
        vt.push_back(mk(1,0,0,32'h0,        1,32'h10,      1,32'hC,       0));
        vt.push_back(mk(0,0,0,32'h0,        1,32'h10,      0,32'h0,       0));
        vt.push_back(mk(0,0,1,32'h100,      1,32'h10,      0,32'h0,       0));
        vt.push_back(mk(0,0,0,32'h0,        1,32'h10,      0,32'h0,       0));
        vt.push_back(mk(1,0,0,32'h0,        1,32'h100,     0,32'h0,       0));
        vt.push_back(mk(1,0,0,32'h0,        1,32'h104,     1,32'h100,     0));
        vt.push_back(mk(1,0,1,32'h40,       1,32'h40,      0,32'h0,       0));
        vt.push_back(mk(1,0,0,32'h0,        1,32'h44,      1,32'h40,      0));
        vt.push_back(mk(0,0,1,32'h102,      1,32'h44,      0,32'h0,       1));
        vt.push_back(mk(1,0,0,32'h0,        0,32'h102,     0,32'h0,       1));
        vt.push_back(mk(0,0,0,32'h0,        0,32'h102,     0,32'h0,       1));
        vt.push_back(mk(0,1,0,32'h0,        0,32'h102,     0,32'h0,       1));
        vt.push_back(mk(0,0,1,32'h200,      1,32'h200,     0,32'h0,       0));
        vt.push_back(mk(1,0,0,32'h0,        1,32'h204,     1,32'h200,     0));
        vt.push_back(mk(1,0,1,32'h302,      0,32'h302,     0,32'h0,       1));
        vt.push_back(mk(0,0,1,32'h306,      0,32'h306,     0,32'h0,       1));
        vt.push_back(mk(0,0,1,32'h10,       1,32'h10,      0,32'h0,       0));
        vt.push_back(mk(1,0,0,32'h0,        1,32'h14,      1,32'h10,      0));
        vt.push_back(mk(1,1,0,32'h0,        0,32'h18,      1,32'h10,      0));
        vt.push_back(mk(0,1,1,32'h80,       1,32'h80,      0,32'h0,       0));
        vt.push_back(mk(1,0,0,32'h0,        1,32'h84,      1,32'h80,      0));
        vt.push_back(mk(0,0,1,32'hFFFFFFFC, 1,32'h84,      0,32'h0,       0));
        vt.push_back(mk(1,0,0,32'h0,        1,32'hFFFFFFFC,0,32'h0,       0));
        vt.push_back(mk(1,0,0,32'h0,        1,32'h0,       1,32'hFFFFFFFC,0));
        vt.push_back(mk(1,0,0,32'h0,        1,32'h4,       1,32'h0,       0));
        vt.push_back(mk(0,0,0,32'h0,        1,32'h4,       0,32'h0,       0));
        vt.push_back(mk(1,1,0,32'h0,        1,32'h8,       1,32'h4,       0));

        // Reset state, including no request while held in reset.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("por_release_req",  32'(ifc.mem_req_o), 32'd1);
        chk("por_release_addr", ifc.mem_addr_o,     32'h0);

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].ack, vt[i].stall, vt[i].redir, vt[i].raddr);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_req", i),   32'(ifc.mem_req_o),   32'(vt[i].e_req));
            chk($sformatf("vec%0d_addr", i),  ifc.mem_addr_o,       vt[i].e_addr);
            chk($sformatf("vec%0d_valid", i), 32'(ifc.valid_o),     32'(vt[i].e_valid));
            chk($sformatf("vec%0d_exc", i),   32'(ifc.exception_o), 32'(vt[i].e_exc));
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d_pc", i),    ifc.pc_o,          vt[i].e_pc);
                chk($sformatf("vec%0d_instr", i), ifc.instruction_o, vt[i].e_pc ^ K);
            end
        end

        // Reset asserted mid-stall (skid buffer full).
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("stall_hold_req", 32'(ifc.mem_req_o), 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("rst_stall");
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_stall_addr", ifc.mem_addr_o, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_stall_first_pc",    ifc.pc_o,          32'h0);
        chk("rst_stall_first_instr", ifc.instruction_o, K);
        chk("rst_stall_first_valid", 32'(ifc.valid_o),  32'd1);

        // Reset asserted with a request outstanding.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("rst_req");
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_req_addr", ifc.mem_addr_o,     32'h0);
        chk("rst_req_req",  32'(ifc.mem_req_o), 32'd1);

        // Random traffic against a stream-level model: consumed words must form
        // BOOT_ADDR, +4, +4 ... restarting at each redirect target.
        consumed    = 0;
        exp_pc      = 32'h0;
        need_bubble = 1'b0;
        addr_hold   = 1'b0;
        held_addr   = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (need_bubble) chk("rand_redirect_bubble", 32'(ifc.valid_o), 32'd0);
            if (addr_hold)   chk("rand_addr_stable", ifc.mem_addr_o, held_addr);
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 19) == 0);
            ra = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            ak = ifc.mem_req_o && ($urandom_range(0, 9) < 7);
            drive(ak, st, rd, ra);
            need_bubble = rd;
            if (rd) begin
                exp_pc = ra;
            end else if (ifc.valid_o && !st) begin
                chk("rand_pc",    ifc.pc_o,          exp_pc);
                chk("rand_instr", ifc.instruction_o, exp_pc ^ K);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            addr_hold = ifc.mem_req_o && !ak;
            held_addr = ifc.mem_addr_o;
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rand_progress", 32'(consumed >= 600), 32'd1);
        chk("rand_no_exc",   32'(ifc.exception_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
